cache_bus_arbiter: RTL and testbench
====================================

# cache_bus_arbiter

Shares one cache-to-memory bus port between the instruction-side and data-side cache clients. Each side, and the bus, uses the core/cache request–response handshake: a `reqcyc/reqack` beat channel and a `respcyc/respack` beat channel. The block grants one client at a time and holds ownership for the whole transaction: header, write data burst or read response burst. It sits between the I/D caches and the memory-side bus interface.

## Interface
- `DATA_WIDTH`, 64, width of request, write-data and response beats
- `TAG_WIDTH`, 13, tag width; bit `TAG_WIDTH-1` is READ(1)/WRITE(0)
- `BURST_BEATS`, 8, data beats per write burst and per read response
- `clk`  in  1  single clock
- `reset`  in  1  synchronous, active-high
- `i_req`, `d_req`  in  DATA_WIDTH  request/header or write-data beat from I-side, D-side
- `i_reqtag`, `d_reqtag`  in  TAG_WIDTH  request tag from I-side, D-side
- `i_reqcyc`, `d_reqcyc`  in  1  beat valid from I-side, D-side
- `i_reqack`, `d_reqack`  out  1  beat accepted, to I-side, D-side
- `i_resp`, `d_resp`  out  DATA_WIDTH  response beat to I-side, D-side
- `i_resptag`, `d_resptag`  out  TAG_WIDTH  response tag to I-side, D-side
- `i_respcyc`, `d_respcyc`  out  1  response beat valid to I-side, D-side
- `i_respack`, `d_respack`  in  1  response beat consumed, from I-side, D-side
- `bus_req`, `bus_reqtag`, `bus_reqcyc`  out  DATA_WIDTH/TAG_WIDTH/1  granted client's request channel
- `bus_reqack`  in  1  bus accepted beat
- `bus_resp`, `bus_resptag`, `bus_respcyc`  in  DATA_WIDTH/TAG_WIDTH/1  bus response channel
- `bus_respack`  out  1  owner consumed response beat

## Operation
- Beat transfer on any channel: the cycle where `cyc && ack` are both high. A source holds data, tag and `cyc` stable until that cycle.
- FSM states: IDLE, HDR, WDATA, RESP. Registered `owner` is INSTR or DATA.
- IDLE: if any `*_reqcyc` is high, pick a winner, latch `owner`, go to HDR.
- HDR: `bus_req/bus_reqtag/bus_reqcyc` carry the owner's signals; owner `*_reqack` = `bus_reqack`.
  - On header transfer with tag MSB=READ: go to RESP.
  - On header transfer with tag MSB=WRITE: go to WDATA.
- WDATA: same forwarding as HDR. Count transferred beats; after beat `BURST_BEATS` go to IDLE.
- RESP: `bus_resp/bus_resptag/bus_respcyc` go to the owner's response port; `bus_respack` = owner `*_respack`. Count transferred beats; after beat `BURST_BEATS` go to IDLE.
- Response routing uses `owner`, not the tag. Tags pass through unmodified both ways.
- Non-owner and IDLE outputs: `*_reqack`=0, `*_respcyc`=0, data/tag outputs 0. `bus_reqcyc`=0 in IDLE and RESP; `bus_respack`=0 outside RESP.
- `bus_respcyc` outside RESP is ignored and never acknowledged.
- Beat counter width: `$clog2(BURST_BEATS+1)`. Cleared on entry to WDATA/RESP; the exit compare is against `BURST_BEATS`.

## Timing
- Reset: state=IDLE, counter=0, `owner`=INSTR, last-grant=INSTR, all outputs 0.
- Reset mid-transaction: abandons the transaction; IDLE on the next cycle with no partial ack.
- Arbitration latency: 1 cycle from `*_reqcyc` rising in IDLE to `bus_reqcyc` high. Bus-side forwarding is combinational from the granted client in HDR/WDATA/RESP.
- Back-to-back: after the last beat, there is one IDLE cycle before the next grant. Minimum read = 1 + 1 + BURST_BEATS cycles. Minimum write = 1 + 1 + BURST_BEATS cycles.
- A client dropping `reqcyc` in HDR before ack is a protocol violation; the block stays in HDR.

## Configuration
- `CACHE_ARB_ROUND_ROBIN_EN` defined: on simultaneous requests in IDLE, grant the side not granted last. Last-grant updates at each grant. After reset, DATA wins the first tie.
- Undefined: fixed priority, DATA always beats INSTR. The last-grant register is not built.

## Structure
- Package `cache_arb_pkg` holds:
  - state enum (IDLE, HDR, WDATA, RESP)
  - owner encoding DATA=1'b1, INSTR=1'b0
  - READ=1'b1, WRITE=1'b0
  - request-type constants MEMORY=4'b0001, MMIO=4'b0011, PORT=4'b0100, IRQ=4'b1110
- Sub-module `cache_arb_pick`: combinational winner selection from the two `reqcyc` inputs plus last-grant. It holds the macro-dependent logic.

## Test plan
- I-side read, tag MSB=1, bus acks after 2 cycles, 8 response beats with one `i_respack` stall -> `i_resp` shows beats 0..7 in order, `d_*` stay 0, IDLE after beat 8.
- D-side write with 8 beats 0x10..0x17 -> `bus_req` carries the header, then 0x10..0x17. Each `d_reqack` mirrors `bus_reqack`; no `bus_respack` pulses.
- Both request in the same cycle, twice back-to-back -> with the macro: D then I, then D again; without: D both times with I waiting.
- I read in RESP while D asserts `d_reqcyc` -> `d_reqack` stays 0 until I's 8th beat. D is granted the cycle after the IDLE cycle.
- `reset` pulsed during WDATA beat 3 -> next cycle all outputs 0, state IDLE. A following I read completes normally.

Source files
------------

// File: rtl/cache_arb_pkg.sv
// rtl/cache_arb_pkg.sv - shared state, owner, direction and request-type encodings for the cache bus arbiter
package cache_arb_pkg;

  typedef enum logic [1:0] {IDLE, HDR, WDATA, RESP} state_t;

  localparam logic INSTR = 1'b0;
  localparam logic DATA  = 1'b1;

  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

  localparam logic [3:0] MEMORY = 4'b0001;
  localparam logic [3:0] MMIO   = 4'b0011;
  localparam logic [3:0] PORT   = 4'b0100;
  localparam logic [3:0] IRQ    = 4'b1110;

endpackage

// File: rtl/cache_arb_pick.sv
// rtl/cache_arb_pick.sv - I/D winner selection; round-robin tie-break when CACHE_ARB_ROUND_ROBIN_EN is defined
module cache_arb_pick
  import cache_arb_pkg::*;
(
  input  logic i_reqcyc,
  input  logic d_reqcyc,
`ifdef CACHE_ARB_ROUND_ROBIN_EN
  input  logic last_grant,
`endif
  output logic any,
  output logic winner
);

  always_comb begin
    any = i_reqcyc | d_reqcyc;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
    // On a tie the side that did not win last time goes first.
    if (i_reqcyc && d_reqcyc) winner = ~last_grant;
    else                      winner = d_reqcyc ? DATA : INSTR;
`else
    winner = d_reqcyc ? DATA : INSTR;
`endif
  end

endmodule

// File: rtl/cache_bus_arbiter.sv
// rtl/cache_bus_arbiter.sv - shares one memory bus port between I and D caches, owner held per transaction (CACHE_ARB_ROUND_ROBIN_EN)
module cache_bus_arbiter
  import cache_arb_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int TAG_WIDTH   = 13,
  parameter int BURST_BEATS = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] i_req,
  input  logic [DATA_WIDTH-1:0] d_req,
  input  logic [TAG_WIDTH-1:0]  i_reqtag,
  input  logic [TAG_WIDTH-1:0]  d_reqtag,
  input  logic                  i_reqcyc,
  input  logic                  d_reqcyc,
  output logic                  i_reqack,
  output logic                  d_reqack,
  output logic [DATA_WIDTH-1:0] i_resp,
  output logic [DATA_WIDTH-1:0] d_resp,
  output logic [TAG_WIDTH-1:0]  i_resptag,
  output logic [TAG_WIDTH-1:0]  d_resptag,
  output logic                  i_respcyc,
  output logic                  d_respcyc,
  input  logic                  i_respack,
  input  logic                  d_respack,
  output logic [DATA_WIDTH-1:0] bus_req,
  output logic [TAG_WIDTH-1:0]  bus_reqtag,
  output logic                  bus_reqcyc,
  input  logic                  bus_reqack,
  input  logic [DATA_WIDTH-1:0] bus_resp,
  input  logic [TAG_WIDTH-1:0]  bus_resptag,
  input  logic                  bus_respcyc,
  output logic                  bus_respack
);

  localparam int CW = $clog2(BURST_BEATS + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_BEATS);

  state_t        state, state_nx;
  logic          owner, owner_nx;
  logic [CW-1:0] cnt, cnt_nx, cnt_inc;
  logic          any, winner;
  logic          sel_d, fwd_req, fwd_resp;
  logic          own_reqcyc, own_respack, own_tag_msb;
  logic          req_xfer, resp_xfer;

`ifdef CACHE_ARB_ROUND_ROBIN_EN
  logic last_grant;
`endif

  cache_arb_pick u_pick (
    .i_reqcyc   (i_reqcyc),
    .d_reqcyc   (d_reqcyc),
`ifdef CACHE_ARB_ROUND_ROBIN_EN
    .last_grant (last_grant),
`endif
    .any        (any),
    .winner     (winner)
  );

  // Reset gates forwarding so an abandoned transaction never sees a partial ack.
  assign sel_d       = (owner == DATA);
  assign cnt_inc     = cnt + CW'(1);
  assign fwd_req     = !reset && (state == HDR || state == WDATA);
  assign fwd_resp    = !reset && (state == RESP);
  assign own_reqcyc  = sel_d ? d_reqcyc : i_reqcyc;
  assign own_respack = sel_d ? d_respack : i_respack;
  assign own_tag_msb = sel_d ? d_reqtag[TAG_WIDTH-1] : i_reqtag[TAG_WIDTH-1];
  assign req_xfer    = fwd_req && own_reqcyc && bus_reqack;
  assign resp_xfer   = fwd_resp && bus_respcyc && own_respack;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      owner <= INSTR;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      owner <= owner_nx;
      cnt   <= cnt_nx;
    end
  end

`ifdef CACHE_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk) begin
    if (reset)                      last_grant <= INSTR;
    else if (state == IDLE && any)  last_grant <= winner;
  end
`endif

  always_comb begin
    state_nx    = state;
    owner_nx    = owner;
    cnt_nx      = cnt;
    i_reqack    = 1'b0;
    d_reqack    = 1'b0;
    i_resp      = '0;
    d_resp      = '0;
    i_resptag   = '0;
    d_resptag   = '0;
    i_respcyc   = 1'b0;
    d_respcyc   = 1'b0;
    bus_req     = '0;
    bus_reqtag  = '0;
    bus_reqcyc  = 1'b0;
    bus_respack = 1'b0;

    if (fwd_req) begin
      bus_req    = sel_d ? d_req : i_req;
      bus_reqtag = sel_d ? d_reqtag : i_reqtag;
      bus_reqcyc = own_reqcyc;
      if (sel_d) d_reqack = bus_reqack;
      else       i_reqack = bus_reqack;
    end

    // Response routing follows the registered owner; the tag is passed through untouched.
    if (fwd_resp) begin
      bus_respack = own_respack;
      if (sel_d) begin
        d_resp    = bus_resp;
        d_resptag = bus_resptag;
        d_respcyc = bus_respcyc;
      end else begin
        i_resp    = bus_resp;
        i_resptag = bus_resptag;
        i_respcyc = bus_respcyc;
      end
    end

    case (state)
      IDLE: begin
        if (any) begin
          owner_nx = winner;
          state_nx = HDR;
        end
      end
      HDR: begin
        if (req_xfer) begin
          cnt_nx   = '0;
          state_nx = (own_tag_msb == WRITE) ? WDATA : RESP;
        end
      end
      WDATA: begin
        if (req_xfer) begin
          if (cnt_inc == LAST_BEAT) begin
            cnt_nx   = '0;
            state_nx = IDLE;
          end else begin
            cnt_nx = cnt_inc;
          end
        end
      end
      RESP: begin
        if (resp_xfer) begin
          if (cnt_inc == LAST_BEAT) begin
            cnt_nx   = '0;
            state_nx = IDLE;
          end else begin
            cnt_nx = cnt_inc;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// tb/tb_cache_bus_arbiter.sv - table-driven and scoreboard bench for cache_bus_arbiter
module tb_cache_bus_arbiter;
  import cache_arb_pkg::*;

  localparam int DW = 64;
  localparam int TW = 13;
  localparam int BB = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] i_req, d_req, i_resp, d_resp, bus_req, bus_resp;
  logic [TW-1:0] i_reqtag, d_reqtag, i_resptag, d_resptag, bus_reqtag, bus_resptag;
  logic          i_reqcyc, d_reqcyc, i_reqack, d_reqack, i_respcyc, d_respcyc;
  logic          i_respack, d_respack, bus_reqcyc, bus_reqack, bus_respcyc, bus_respack;

  cache_bus_arbiter #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .BURST_BEATS(BB)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .d_req(d_req), .i_reqtag(i_reqtag), .d_reqtag(d_reqtag),
    .i_reqcyc(i_reqcyc), .d_reqcyc(d_reqcyc), .i_reqack(i_reqack), .d_reqack(d_reqack),
    .i_resp(i_resp), .d_resp(d_resp), .i_resptag(i_resptag), .d_resptag(d_resptag),
    .i_respcyc(i_respcyc), .d_respcyc(d_respcyc), .i_respack(i_respack), .d_respack(d_respack),
    .bus_req(bus_req), .bus_reqtag(bus_reqtag), .bus_reqcyc(bus_reqcyc), .bus_reqack(bus_reqack),
    .bus_resp(bus_resp), .bus_resptag(bus_resptag), .bus_respcyc(bus_respcyc),
    .bus_respack(bus_respack)
  );

  always #5 clk = ~clk;

  typedef struct { logic [DW-1:0] data; logic [TW-1:0] tag; } beat_t;
  typedef struct { bit side; logic [DW-1:0] data; logic [TW-1:0] tag; } resp_t;
  typedef struct {
    bit side; bit read; logic [TW-1:0] tag; logic [DW-1:0] hdr; logic [DW-1:0] base;
    int delay; int stall; int exp_cycles;
  } vec_t;

  beat_t bus_q[$];
  resp_t resp_q[$];
  vec_t  vt[5];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_resp_cyc = 0;
  bit mon_active = 0;
  bit mon_write = 0;
  bit cur_side = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic resp_pop(input bit side, input logic [DW-1:0] data, input logic [TW-1:0] tag);
    resp_t e;
    if (resp_q.size() == 0) begin
      check("resp_unexpected", 64'(side) + 64'd1, 64'd0);
    end else begin
      e = resp_q.pop_front();
      check("resp_side", 64'(side), 64'(e.side));
      check("resp_data", data, e.data);
      check("resp_tag", 64'(tag), 64'(e.tag));
    end
  endtask

  always @(negedge clk) begin
    beat_t eb;
    if (bus_reqcyc && bus_reqack) begin
      if (bus_q.size() == 0) begin
        check("bus_req_unexpected", bus_req, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        eb = bus_q.pop_front();
        check("bus_req", bus_req, eb.data);
        check("bus_reqtag", 64'(bus_reqtag), 64'(eb.tag));
      end
    end
    if (i_respcyc && i_respack) resp_pop(1'b0, i_resp, i_resptag);
    if (d_respcyc && d_respack) resp_pop(1'b1, d_resp, d_resptag);
    if (mon_active) begin
      if (bus_reqcyc) check("owner_reqack", 64'(cur_side ? d_reqack : i_reqack), 64'(bus_reqack));
      check("other_reqack", 64'(cur_side ? i_reqack : d_reqack), 64'd0);
      check("other_respcyc", 64'(cur_side ? i_respcyc : d_respcyc), 64'd0);
      check("other_resp", cur_side ? i_resp : d_resp, 64'd0);
      check("other_resptag", 64'(cur_side ? i_resptag : d_resptag), 64'd0);
      if (mon_write) check("write_no_respack", 64'(bus_respack), 64'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_side(input bit side, input logic [DW-1:0] data, input logic [TW-1:0] tag,
                            input logic cycv);
    if (side) begin d_req = data; d_reqtag = tag; d_reqcyc = cycv; end
    else      begin i_req = data; i_reqtag = tag; i_reqcyc = cycv; end
  endtask

  function automatic logic side_ack(input bit side);
    return side ? d_reqack : i_reqack;
  endfunction

  // Presents header then nbeats data beats, each held until acked; leaves the last beat driven.
  task automatic client(input bit side, input logic [TW-1:0] tag, input logic [DW-1:0] hdr,
                        input logic [DW-1:0] base, input int nbeats,
                        output int first_ack, output int last_ack);
    first_ack = -1;
    last_ack  = -1;
    for (int k = 0; k <= nbeats; k++) begin
      int w = 0;
      drive_side(side, (k == 0) ? hdr : base + 64'(k - 1), tag, 1'b1);
      do begin @(negedge clk); w++; end while (!side_ack(side) && w < 300);
      if (!side_ack(side)) begin
        check("client_ack_timeout", 64'(k), 64'hFFFF);
        return;
      end
      if (k == 0) first_ack = cyc;
      last_ack = cyc;
      tick();
    end
  endtask

  task automatic respond(input bit side, input logic [TW-1:0] tag, input logic [DW-1:0] base,
                         input int stall_beat);
    int w = 0;
    do begin @(negedge clk); w++; end while (!(bus_reqcyc && bus_reqack) && w < 300);
    if (!(bus_reqcyc && bus_reqack)) begin
      check("resp_hdr_timeout", 64'd0, 64'd1);
      return;
    end
    tick();
    for (int k = 0; k < BB; k++) begin
      bus_resp = base + 64'(k); bus_resptag = tag; bus_respcyc = 1'b1;
      resp_q.push_back('{side: side, data: base + 64'(k), tag: tag});
      if (k == stall_beat) begin
        if (side) d_respack = 1'b0; else i_respack = 1'b0;
        @(negedge clk);
        check("resp_stall_no_ack", 64'(bus_respack), 64'd0);
        tick();
        if (side) d_respack = 1'b1; else i_respack = 1'b1;
      end
      w = 0;
      do begin @(negedge clk); w++; end while (!bus_respack && w < 300);
      if (!bus_respack) begin
        check("resp_ack_timeout", 64'(k), 64'hFFFF);
        return;
      end
      last_resp_cyc = cyc;
      tick();
    end
    bus_respcyc = 1'b0; bus_resp = '0; bus_resptag = '0;
  endtask

  task automatic bus_acker(input bit is_write, input int delay, input int stall_beat);
    int n = 0;
    int seen = 0;
    int w = 0;
    bit stalled = 0;
    int total = is_write ? BB + 1 : 1;
    bus_reqack = (delay == 0);
    while (n < total && w < 300) begin
      @(negedge clk);
      w++;
      if (bus_reqcyc && bus_reqack) n++;
      else if (bus_reqcyc && n == 0) seen++;
      tick();
      bus_reqack = (n > 0) || (seen >= delay);
      if (is_write && n == stall_beat && !stalled) begin
        bus_reqack = 1'b0;
        stalled = 1;
      end
    end
    bus_reqack = 1'b0;
    if (n < total) check("bus_ack_timeout", 64'(n), 64'(total));
  endtask

  task automatic check_quiet(input string tagname);
    check({tagname, "_bus_reqcyc"}, 64'(bus_reqcyc), 64'd0);
    check({tagname, "_bus_req"}, bus_req, 64'd0);
    check({tagname, "_bus_respack"}, 64'(bus_respack), 64'd0);
    check({tagname, "_reqacks"}, 64'({i_reqack, d_reqack}), 64'd0);
    check({tagname, "_respcycs"}, 64'({i_respcyc, d_respcyc}), 64'd0);
    check({tagname, "_resps"}, i_resp | d_resp, 64'd0);
  endtask

  task automatic run_txn(input vec_t r);
    int t0, fa, la, t_end;
    tick();
    t0 = cyc;
    t_end = 0;
    cur_side = r.side; mon_active = 1; mon_write = !r.read;
    bus_q.push_back('{data: r.hdr, tag: r.tag});
    if (!r.read) begin
      for (int k = 0; k < BB; k++) bus_q.push_back('{data: r.base + 64'(k), tag: r.tag});
      bus_respcyc = 1'b1; bus_resp = 64'hDEAD_BEEF; bus_resptag = 13'h1ABC;
    end
    fork
      begin
        client(r.side, r.tag, r.hdr, r.base, r.read ? 0 : BB, fa, la);
        drive_side(r.side, '0, '0, 1'b0);
        if (!r.read) t_end = la;
      end
      bus_acker(!r.read, r.delay, r.stall);
      if (r.read) begin
        respond(r.side, r.tag, r.base, r.stall);
        t_end = last_resp_cyc;
      end
    join
    bus_respcyc = 1'b0; bus_resp = '0; bus_resptag = '0;
    check("txn_cycles", 64'(t_end - t0 + 1), 64'(r.exp_cycles));
    @(negedge clk);
    check_quiet("after_txn");
    mon_active = 0; mon_write = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, fa, la, fa2, la2, fad, lad;
    vt[0] = '{side: 1'b0, read: 1'b1, tag: 13'h1005, hdr: {60'hA0, MEMORY}, base: 64'h100,
              delay: 2, stall: 3, exp_cycles: 13};
    vt[1] = '{side: 1'b1, read: 1'b0, tag: 13'h0003, hdr: {60'hB0, MMIO}, base: 64'h10,
              delay: 0, stall: -1, exp_cycles: 10};
    vt[2] = '{side: 1'b1, read: 1'b1, tag: 13'h1FFF, hdr: {60'hC0, PORT}, base: 64'h200,
              delay: 1, stall: 7, exp_cycles: 12};
    vt[3] = '{side: 1'b0, read: 1'b0, tag: 13'h0FFF, hdr: {60'hD0, IRQ}, base: 64'h300,
              delay: 0, stall: 1, exp_cycles: 11};
    vt[4] = '{side: 1'b1, read: 1'b1, tag: 13'h1001, hdr: {60'hE0, MEMORY}, base: 64'h400,
              delay: 0, stall: -1, exp_cycles: 10};

    reset = 1'b1;
    i_req = '0; d_req = '0; i_reqtag = '0; d_reqtag = '0; i_reqcyc = 0; d_reqcyc = 0;
    i_respack = 1'b1; d_respack = 1'b1;
    bus_reqack = 1'b0; bus_resp = '0; bus_resptag = '0; bus_respcyc = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check_quiet("reset");

    // Simultaneous requests straight out of reset; D re-requests immediately after its first.
    tick();
    reset = 1'b0;
    t0 = cyc;
    bus_reqack = 1'b1;
    bus_q.push_back('{data: 64'hD1, tag: 13'h0001});
    for (int k = 0; k < BB; k++) bus_q.push_back('{data: 64'h200 + 64'(k), tag: 13'h0001});
`ifdef CACHE_ARB_ROUND_ROBIN_EN
    bus_q.push_back('{data: 64'h11, tag: 13'h0002});
    for (int k = 0; k < BB; k++) bus_q.push_back('{data: 64'h400 + 64'(k), tag: 13'h0002});
    bus_q.push_back('{data: 64'hD2, tag: 13'h0001});
    for (int k = 0; k < BB; k++) bus_q.push_back('{data: 64'h300 + 64'(k), tag: 13'h0001});
`else
    bus_q.push_back('{data: 64'hD2, tag: 13'h0001});
    for (int k = 0; k < BB; k++) bus_q.push_back('{data: 64'h300 + 64'(k), tag: 13'h0001});
    bus_q.push_back('{data: 64'h11, tag: 13'h0002});
    for (int k = 0; k < BB; k++) bus_q.push_back('{data: 64'h400 + 64'(k), tag: 13'h0002});
`endif
    fork
      begin
        client(1'b1, 13'h0001, 64'hD1, 64'h200, BB, fa, la);
        client(1'b1, 13'h0001, 64'hD2, 64'h300, BB, fa2, la2);
        drive_side(1'b1, '0, '0, 1'b0);
      end
      begin
        client(1'b0, 13'h0002, 64'h11, 64'h400, BB, fad, lad);
        drive_side(1'b0, '0, '0, 1'b0);
      end
    join
    bus_reqack = 1'b0;
    check("arb_latency", 64'(fa - t0), 64'd1);
    check("arb_order_drained", 64'(bus_q.size()), 64'd0);

    // D requests while I is mid-response; D must wait for I's last beat plus one IDLE cycle.
    tick();
    bus_reqack = 1'b1;
    bus_q.push_back('{data: 64'h77, tag: 13'h1005});
    bus_q.push_back('{data: 64'h88, tag: 13'h0006});
    for (int k = 0; k < BB; k++) bus_q.push_back('{data: 64'h500 + 64'(k), tag: 13'h0006});
    fork
      begin
        client(1'b0, 13'h1005, 64'h77, 64'h0, 0, fa, la);
        drive_side(1'b0, '0, '0, 1'b0);
      end
      respond(1'b0, 13'h1005, 64'h600, -1);
      begin
        int w = 0;
        do begin @(negedge clk); w++; end while (!(bus_reqcyc && bus_reqack) && w < 300);
        tick();
        client(1'b1, 13'h0006, 64'h88, 64'h500, BB, fad, lad);
        drive_side(1'b1, '0, '0, 1'b0);
      end
    join
    bus_reqack = 1'b0;
    check("d_grant_after_idle", 64'(fad - last_resp_cyc), 64'd2);

    // Reset lands while the third write data beat is presented.
    tick();
    bus_reqack = 1'b1;
    bus_q.push_back('{data: 64'h99, tag: 13'h0007});
    bus_q.push_back('{data: 64'h700, tag: 13'h0007});
    bus_q.push_back('{data: 64'h701, tag: 13'h0007});
    drive_side(1'b1, 64'h99, 13'h0007, 1'b1);
    tick();
    tick();
    drive_side(1'b1, 64'h700, 13'h0007, 1'b1);
    tick();
    drive_side(1'b1, 64'h701, 13'h0007, 1'b1);
    tick();
    drive_side(1'b1, 64'h702, 13'h0007, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive_side(1'b1, '0, '0, 1'b0);
    bus_reqack = 1'b0;
    @(negedge clk);
    check_quiet("post_reset");
    check("reset_partial_drained", 64'(bus_q.size()), 64'd0);

    for (int i = 0; i < 5; i++) run_txn(vt[i]);

    check("bus_q_drained", 64'(bus_q.size()), 64'd0);
    check("resp_q_drained", 64'(resp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
